// File: rtl/count_pwm_gen_if.sv
// Bus bundle between the upstream counter, the duty source and the PWM generator.
// The generator takes the slave view; a driver or bench takes the master view.
interface count_pwm_gen_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] duty_in;
    logic             duty_load;
    logic             pwm_out;
    logic             period_start;
    logic [WIDTH-1:0] duty_active;
    logic             load_pending;

    modport master (
        output en, count, duty_in, duty_load,
        input  pwm_out, period_start, duty_active, load_pending
    );

    modport slave (
        input  en, count, duty_in, duty_load,
        output pwm_out, period_start, duty_active, load_pending
    );
endinterface

// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external free-running up counter. Duty updates
// are shadowed and only take effect when the counter wraps to zero.
module count_pwm_gen #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    count_pwm_gen_if.slave bus
);
    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_ARMED = 2'd1;
    localparam logic [1:0]       ST_RUN   = 2'd2;
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

    logic [1:0]       state_q,        state_d;
    logic [WIDTH-1:0] count_prev_q;
    logic [WIDTH-1:0] duty_shadow_q,  duty_shadow_d;
    logic [WIDTH-1:0] duty_active_q,  duty_active_d;
    logic             load_pending_q, load_pending_d;
    logic             pwm_q,          pwm_d;
    logic             period_start_q, period_start_d;
    logic             wrap_s;
    logic             live_s;

    // Wrap detection, shadow/apply bookkeeping and next-state/output decode
    always_comb begin
        wrap_s         = (bus.count == ZERO) && (count_prev_q != ZERO);
        live_s         = bus.en && (state_q != ST_IDLE);
        state_d        = state_q;
        duty_shadow_d  = duty_shadow_q;
        duty_active_d  = duty_active_q;
        load_pending_d = load_pending_q;
        pwm_d          = 1'b0;
        period_start_d = 1'b0;

        if (bus.duty_load) begin
            duty_shadow_d  = bus.duty_in;
            load_pending_d = 1'b1;
        end else begin
            duty_shadow_d  = duty_shadow_q;
        end

        // A load coinciding with the wrap bypasses the shadow
        if (live_s && wrap_s) begin
            duty_active_d  = bus.duty_load ? bus.duty_in : duty_shadow_q;
            load_pending_d = 1'b0;
        end else begin
            duty_active_d  = duty_active_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else if (wrap_s) begin
                    state_d        = ST_RUN;
                    period_start_d = 1'b1;
                    pwm_d          = (bus.count < duty_active_d);
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_RUN: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d        = ST_RUN;
                    period_start_d = wrap_s;
                    pwm_d          = (bus.count < duty_active_d);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            count_prev_q   <= ONES;
            duty_shadow_q  <= ZERO;
            duty_active_q  <= ZERO;
            load_pending_q <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_prev_q   <= bus.count;
            duty_shadow_q  <= duty_shadow_d;
            duty_active_q  <= duty_active_d;
            load_pending_q <= load_pending_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = period_start_q;
    assign bus.duty_active  = duty_active_q;
    assign bus.load_pending = load_pending_q;
endmodule

// File: doc/count_pwm_gen.md
Name: count_pwm_gen

Overview:
- Downstream consumer of the free-running 4-bit up counter's `out` bus.
- Compares the incoming count against a programmable duty value and produces a registered PWM output plus a period-start strobe.
- Duty updates are double-buffered so that they take effect only at a count wrap. This prevents glitched or truncated pulses.
- Used to build dimming and duty-cycle test fixtures from the counter stage.

Parameters:
- WIDTH, 4, width of count, duty_in and duty_active; must match the upstream counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  generator enable; low forces the FSM to IDLE.
- count  input  WIDTH  current value from the upstream up counter.
- duty_in  input  WIDTH  new duty value (high cycles per period).
- duty_load  input  1  one-cycle strobe; captures duty_in into the shadow register.
- pwm_out  output  1  registered PWM output.
- period_start  output  1  one-cycle pulse, registered, on each detected wrap while not IDLE.
- duty_active  output  WIDTH  duty value currently applied.
- load_pending  output  1  high while the shadow holds a value not yet applied.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: pwm_out=0, period_start=0, duty_active=0, duty_shadow=0, load_pending=0, state=IDLE, count_prev=all-ones.
- count_prev register: count_prev <= count every cycle, except in reset.
- Wrap detection: wrap = (count==0) && (count_prev!=0).
  - This covers a natural rollover (MAX->0) and an upstream counter reset mid-period.
  - Because count_prev resets to all-ones, a count of 0 on the first cycle after rst counts as a wrap.
- Shadow load:
  - On duty_load: duty_shadow <= duty_in and load_pending <= 1.
  - A later load before a wrap overwrites the shadow (last write wins).
- Apply at wrap, in ARMED or RUN:
  - duty_active <= duty_load ? duty_in : duty_shadow.
  - load_pending <= 0.
  - duty_active changes only at a wrap or at reset.
- duty_load in IDLE: updates the shadow only; it is applied at the first wrap after entering ARMED.
- FSM:
  - IDLE: pwm_out=0, period_start=0. Goes to ARMED when en=1.
  - ARMED: waiting to align to a period. pwm_out=0. On wrap: apply duty, assert period_start, go to RUN.
  - RUN: pwm_out <= (count < d), where d is the duty value in effect this cycle (the newly applied value on a wrap cycle). period_start <= wrap.
  - Any state with en=0: go to IDLE next cycle; pwm_out=0 and period_start=0 from that edge. duty_active and the shadow are retained.
- Latency: pwm_out and period_start lag count by exactly 1 cycle (registered compare).
- Duty semantics with 2^WIDTH count values per period:
  - duty=0: pwm_out constantly 0.
  - duty=k: pwm_out high for counts 0..k-1.
  - duty=2^WIDTH-1: low only at count MAX.
  - A 100% duty is not representable.
- Comparison is unsigned, WIDTH bits; no overflow is possible.
- Boundaries:
  - Wrap and duty_load in the same cycle: duty_in is applied directly.
  - Upstream counter held at 0: only the first cycle is a wrap (count_prev becomes 0).
  - rst mid-period: all outputs return to their reset values at the next edge, regardless of en.

Test Plan:
1. Counter free-running, rst pulsed then en=1, duty_load with duty_in=4 in IDLE -> first wrap: period_start=1 one cycle after count=0; duty_active=4; pwm_out high exactly 4 of every 16 cycles (counts 0..3, delayed 1 cycle); load_pending falls at the wrap.
2. RUN with duty_active=4, duty_load duty_in=10 at count=7 -> remainder of the current period still uses 4; load_pending=1 until the next wrap; the next period has 10 high cycles.
3. duty_in=0 and then duty_in=15 -> pwm_out stuck 0 for a full period; then high 15 cycles, low 1 (count=15).
4. duty_load duty_in=6 in the same cycle count==0 -> duty_active=6 immediately; pwm high counts 0..5 in that same period.
5. Upstream counter reset while count=9 (count jumps to 0) -> period_start pulses; pending duty is applied; PWM restarts from count 0.
6. en dropped for 3 cycles in RUN, then raised -> pwm_out=0 the edge after en=0; ARMED on re-enable with no pwm until the next wrap; duty_active is retained. Separately, rst asserted in RUN -> all outputs 0 at the next edge.
